// File: rtl/imdct_short_engine.sv
// 12-point short-block IMDCT for one MP3 short window: loads six signed lines X[0..5],
// then emits twelve rounded, saturated time samples from a 6-tap MAC per output.
module imdct_short_engine #(
    parameter int COEF_FRAC = 17
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [17:0] in_data_i,
    output logic        rom_enable_o,
    output logic [3:0]  rom_n_o,
    output logic [2:0]  rom_k_o,
    input  logic [17:0] rom_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [17:0] out_data_o,
    output logic [3:0]  out_index_o,
    output logic        out_last_o
);

    // state   | meaning
    // LOAD    | accepting X[0..5], in_ready high
    // MAC     | 7 cycles: ROM reads on c=0..5, accumulate on c=1..6
    // EMIT    | x[n] presented, waits for out_ready
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_MAC  = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    localparam logic [2:0]        LAST_WORD = 3'd5;
    localparam logic [2:0]        MAC_LAST  = 3'd6;
    localparam logic [3:0]        N_LAST    = 4'd11;
    localparam logic signed [39:0] RND_HALF = 40'sd1 <<< (COEF_FRAC - 1);
    localparam logic signed [39:0] SAT_MAX  = 40'sd131071;
    localparam logic signed [39:0] SAT_MIN  = -40'sd131072;

    state_t state_q, state_d;

    logic [2:0]         load_cnt_q, load_cnt_d;
    logic [3:0]         n_q, n_d;
    logic [2:0]         c_q, c_d;
    logic signed [38:0] acc_q, acc_d;
    logic signed [17:0] x_q [6];
    logic signed [17:0] x_d [6];
    logic [3:0]         rom_n_q, rom_n_d;
    logic [2:0]         rom_k_q, rom_k_d;
    logic [17:0]        out_data_q, out_data_d;
    logic [3:0]         out_index_q, out_index_d;

    logic [2:0]         x_sel;
    logic signed [35:0] prod;
    logic signed [38:0] acc_sum;
    logic signed [39:0] rnd;
    logic signed [39:0] shifted;
    logic [17:0]        sat_res;

    // ROM data lags the read by one cycle, so cycle c multiplies by X[c-1]
    always_comb begin
        x_sel   = (c_q == 3'd0) ? 3'd0 : (c_q - 3'd1);
        prod    = $signed(rom_data_i) * x_q[x_sel];
        acc_sum = acc_q + {{3{prod[35]}}, prod};
        rnd     = {acc_sum[38], acc_sum} + RND_HALF;
        shifted = rnd >>> COEF_FRAC;
        if (shifted > SAT_MAX) begin
            sat_res = 18'h1FFFF;
        end else if (shifted < SAT_MIN) begin
            sat_res = 18'h20000;
        end else begin
            sat_res = shifted[17:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid_i && (load_cnt_q == LAST_WORD)) begin
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                if (c_q == MAC_LAST) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready_i) begin
                    state_d = (n_q == N_LAST) ? ST_LOAD : ST_MAC;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        in_ready_o   = (state_q == ST_LOAD);
        rom_enable_o = (state_q == ST_MAC) && (c_q != MAC_LAST);
        rom_n_o      = rom_enable_o ? n_q : rom_n_q;
        rom_k_o      = rom_enable_o ? c_q : rom_k_q;
        out_valid_o  = (state_q == ST_EMIT);
        out_data_o   = out_data_q;
        out_index_o  = out_index_q;
        out_last_o   = out_valid_o && (out_index_q == N_LAST);
    end

    always_comb begin
        load_cnt_d  = load_cnt_q;
        n_d         = n_q;
        c_d         = c_q;
        acc_d       = acc_q;
        x_d         = x_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        rom_n_d     = rom_n_q;
        rom_k_d     = rom_k_q;

        if (rom_enable_o) begin
            rom_n_d = n_q;
            rom_k_d = c_q;
        end

        case (state_q)
            ST_LOAD: begin
                if (in_valid_i) begin
                    x_d[load_cnt_q] = in_data_i;
                    if (load_cnt_q == LAST_WORD) begin
                        load_cnt_d = 3'd0;
                        n_d        = 4'd0;
                        c_d        = 3'd0;
                        acc_d      = '0;
                    end else begin
                        load_cnt_d = load_cnt_q + 3'd1;
                    end
                end
            end
            ST_MAC: begin
                if (c_q != 3'd0) begin
                    acc_d = acc_sum;
                end
                if (c_q == MAC_LAST) begin
                    c_d         = 3'd0;
                    out_data_d  = sat_res;
                    out_index_d = n_q;
                end else begin
                    c_d = c_q + 3'd1;
                end
            end
            ST_EMIT: begin
                if (out_ready_i) begin
                    acc_d = '0;
                    c_d   = 3'd0;
                    if (n_q == N_LAST) begin
                        n_d        = 4'd0;
                        load_cnt_d = 3'd0;
                    end else begin
                        n_d = n_q + 4'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            load_cnt_q  <= 3'd0;
            n_q         <= 4'd0;
            c_q         <= 3'd0;
            acc_q       <= '0;
            rom_n_q     <= 4'd0;
            rom_k_q     <= 3'd0;
            out_data_q  <= 18'd0;
            out_index_q <= 4'd0;
            for (int i = 0; i < 6; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            load_cnt_q  <= load_cnt_d;
            n_q         <= n_d;
            c_q         <= c_d;
            acc_q       <= acc_d;
            rom_n_q     <= rom_n_d;
            rom_k_q     <= rom_k_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            for (int i = 0; i < 6; i++) begin
                x_q[i] <= x_d[i];
            end
        end
    end

endmodule

// File: tb/tb_imdct_short_engine.sv
// Self-checking bench for imdct_short_engine: registered ROM model plus a plain
// sum-of-products reference with round-half-up and saturation.
module tb_imdct_short_engine;
    localparam int COEF_FRAC = 17;
    typedef logic signed [17:0] xvec_t [6];

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [17:0] in_data_i = '0;
    logic        rom_enable_o;
    logic [3:0]  rom_n_o;
    logic [2:0]  rom_k_o;
    logic [17:0] rom_data_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [17:0] out_data_o;
    logic [3:0]  out_index_o;
    logic        out_last_o;

    imdct_short_engine #(.COEF_FRAC(COEF_FRAC)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .rom_enable_o(rom_enable_o), .rom_n_o(rom_n_o), .rom_k_o(rom_k_o), .rom_data_i(rom_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_index_o(out_index_o), .out_last_o(out_last_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ROM model: registered read, data valid the cycle after the enable
    logic signed [17:0] coef_tab [12][6];
    bit                 rom_use_tab = 1'b0;
    logic signed [17:0] rom_const = '0;
    int                 rom_trace [$];
    int                 rom_emit_bad = 0;

    always @(posedge clk_i) begin
        if (rom_enable_o) begin
            rom_data_i <= rom_use_tab ? coef_tab[rom_n_o][rom_k_o] : rom_const;
            rom_trace.push_back(int'(rom_n_o) * 8 + int'(rom_k_o));
            if (out_valid_o) rom_emit_bad <= rom_emit_bad + 1;
        end
    end

    int got_data [12];
    int got_idx  [12];
    int got_last [12];
    int got_cyc  [12];
    int hs_cyc   [12];
    int hs6;
    bit timeout;
    bit stall_unstable, stall_rom_en, stall_acked;

    function automatic longint coef(int n, int k);
        return rom_use_tab ? longint'(coef_tab[n][k]) : longint'(rom_const);
    endfunction

    function automatic int ref_out(int n, xvec_t xv);
        longint s = 0;
        for (int k = 0; k < 6; k++) s += longint'(xv[k]) * coef(n, k);
        s = (s + (longint'(1) <<< (COEF_FRAC - 1))) >>> COEF_FRAC;
        if (s > 131071) s = 131071;
        if (s < -131072) s = -131072;
        return int'(s);
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        repeat (2) step();
        reset_i = 1'b0;
    endtask

    task automatic random_tab();
        rom_use_tab = 1'b1;
        for (int n = 0; n < 12; n++)
            for (int k = 0; k < 6; k++)
                coef_tab[n][k] = 18'($urandom);
    endtask

    task automatic random_x(output xvec_t xv);
        for (int k = 0; k < 6; k++) xv[k] = 18'($urandom);
    endtask

    task automatic send_frame(input xvec_t xv, input bit gaps);
        int budget;
        for (int k = 0; k < 6; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            in_valid_i = 1'b1;
            in_data_i  = xv[k];
            budget = 200;
            while (!in_ready_o && budget > 0) begin
                step();
                budget--;
            end
            if (budget == 0) timeout = 1'b1;
            hs6 = cyc;
            step();
            in_valid_i = 1'b0;
        end
    endtask

    task automatic collect_frame(input int stall_idx, input int stall_len);
        int budget;
        stall_unstable = 1'b0;
        stall_rom_en   = 1'b0;
        stall_acked    = 1'b0;
        for (int n = 0; n < 12; n++) begin
            budget = 100;
            while (!out_valid_o && budget > 0) begin
                step();
                budget--;
            end
            if (budget == 0) begin
                timeout = 1'b1;
                return;
            end
            got_cyc[n]  = cyc;
            got_data[n] = int'($signed(out_data_o));
            got_idx[n]  = int'(out_index_o);
            got_last[n] = int'(out_last_o);
            if (n == stall_idx && stall_len > 0) begin
                out_ready_i = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    if (!out_valid_o || int'($signed(out_data_o)) != got_data[n] ||
                        int'(out_index_o) != got_idx[n]) stall_unstable = 1'b1;
                    if (rom_enable_o) stall_rom_en = 1'b1;
                    in_valid_i = s[0];
                    in_data_i  = 18'($urandom);
                    if (in_valid_i && in_ready_o) stall_acked = 1'b1;
                end
                in_valid_i  = 1'b0;
                out_ready_i = 1'b1;
            end
            hs_cyc[n] = cyc;
            step();
        end
    endtask

    task automatic run_frame(input xvec_t xv, input bit gaps, input int stall_idx, input int stall_len);
        timeout = 1'b0;
        send_frame(xv, gaps);
        if (!timeout) collect_frame(stall_idx, stall_len);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready_o !== 1'b1)    begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready_o); end
        checks++; if (rom_enable_o !== 1'b0)  begin errors++; $display("FAIL reset_rom_enable got %b exp 0", rom_enable_o); end
        checks++; if (rom_n_o !== 4'd0)       begin errors++; $display("FAIL reset_rom_n got %0d exp 0", rom_n_o); end
        checks++; if (rom_k_o !== 3'd0)       begin errors++; $display("FAIL reset_rom_k got %0d exp 0", rom_k_o); end
        checks++; if (out_valid_o !== 1'b0)   begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid_o); end
        checks++; if (out_data_o !== 18'd0)   begin errors++; $display("FAIL reset_out_data got %0d exp 0", out_data_o); end
        checks++; if (out_index_o !== 4'd0)   begin errors++; $display("FAIL reset_out_index got %0d exp 0", out_index_o); end
        checks++; if (out_last_o !== 1'b0)    begin errors++; $display("FAIL reset_out_last got %b exp 0", out_last_o); end
    endtask

    task automatic test_zero_frame();
        xvec_t xv;
        do_reset();
        random_tab();
        for (int k = 0; k < 6; k++) xv[k] = '0;
        run_frame(xv, 1'b1, -1, 0);
        checks++; if (timeout) begin errors++; $display("FAIL zero_timeout got 1 exp 0"); end
        for (int n = 0; n < 12; n++) begin
            checks++; if (got_data[n] != 0) begin errors++; $display("FAIL zero_data n=%0d got %0d exp 0", n, got_data[n]); end
            checks++; if (got_idx[n] != n)  begin errors++; $display("FAIL zero_index n=%0d got %0d exp %0d", n, got_idx[n], n); end
            checks++; if (got_last[n] != int'(n == 11)) begin errors++; $display("FAIL zero_last n=%0d got %0d exp %0d", n, got_last[n], int'(n == 11)); end
        end
        checks++; if (got_cyc[0] - hs6 != 8) begin errors++; $display("FAIL first_latency got %0d exp 8", got_cyc[0] - hs6); end
        for (int n = 0; n < 11; n++) begin
            checks++; if (got_cyc[n+1] - hs_cyc[n] != 8) begin errors++; $display("FAIL per_output n=%0d got %0d exp 8", n, got_cyc[n+1] - hs_cyc[n]); end
        end
        checks++; if (hs_cyc[11] - hs6 != 96) begin errors++; $display("FAIL frame_len got %0d exp 96", hs_cyc[11] - hs6); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL ready_after_last got %b exp 1", in_ready_o); end
    endtask

    task automatic test_const_rom();
        xvec_t xv;
        do_reset();
        rom_use_tab = 1'b0;
        rom_const = 18'sd65536;
        xv[0] = 18'sd1000;
        for (int k = 1; k < 6; k++) xv[k] = '0;
        rom_trace.delete();
        rom_emit_bad = 0;
        run_frame(xv, 1'b0, -1, 0);
        checks++; if (timeout) begin errors++; $display("FAIL const_timeout got 1 exp 0"); end
        for (int n = 0; n < 12; n++) begin
            checks++; if (got_data[n] != 500) begin errors++; $display("FAIL const_data n=%0d got %0d exp 500", n, got_data[n]); end
        end
        checks++; if (rom_trace.size() != 72) begin errors++; $display("FAIL rom_reads got %0d exp 72", rom_trace.size()); end
        for (int i = 0; i < 72 && i < rom_trace.size(); i++) begin
            checks++; if (rom_trace[i] != (i / 6) * 8 + (i % 6)) begin
                errors++; $display("FAIL rom_addr i=%0d got n=%0d k=%0d exp n=%0d k=%0d", i, rom_trace[i] / 8, rom_trace[i] % 8, i / 6, i % 6);
            end
        end
        checks++; if (rom_emit_bad != 0) begin errors++; $display("FAIL rom_in_emit got %0d exp 0", rom_emit_bad); end
    endtask

    task automatic test_rounding();
        xvec_t xv;
        do_reset();
        rom_use_tab = 1'b0;
        rom_const = 18'sd65536;
        for (int k = 0; k < 6; k++) xv[k] = '0;
        xv[0] = 18'sd3;
        run_frame(xv, 1'b0, -1, 0);
        checks++; if (timeout) begin errors++; $display("FAIL round_timeout got 1 exp 0"); end
        checks++; if (got_data[0] != 2)  begin errors++; $display("FAIL round_pos got %0d exp 2", got_data[0]); end
        checks++; if (got_data[11] != 2) begin errors++; $display("FAIL round_pos_last got %0d exp 2", got_data[11]); end
        xv[0] = -18'sd3;
        run_frame(xv, 1'b0, -1, 0);
        checks++; if (got_data[0] != -1) begin errors++; $display("FAIL round_neg got %0d exp -1", got_data[0]); end
        checks++; if (got_data[7] != -1) begin errors++; $display("FAIL round_neg_mid got %0d exp -1", got_data[7]); end
    endtask

    task automatic test_saturation();
        xvec_t xv;
        do_reset();
        rom_use_tab = 1'b0;
        rom_const = 18'sd131071;
        for (int k = 0; k < 6; k++) xv[k] = 18'sd131071;
        run_frame(xv, 1'b0, -1, 0);
        checks++; if (timeout) begin errors++; $display("FAIL sat_timeout got 1 exp 0"); end
        checks++; if (got_data[0] != 131071) begin errors++; $display("FAIL sat_pos got %0d exp 131071", got_data[0]); end
        for (int k = 0; k < 6; k++) xv[k] = -18'sd131072;
        run_frame(xv, 1'b0, -1, 0);
        checks++; if (got_data[5] != -131072) begin errors++; $display("FAIL sat_neg got %0d exp -131072", got_data[5]); end
    endtask

    task automatic test_backpressure();
        xvec_t xv;
        do_reset();
        random_tab();
        random_x(xv);
        run_frame(xv, 1'b1, 3, 5);
        checks++; if (timeout) begin errors++; $display("FAIL bp_timeout got 1 exp 0"); end
        for (int n = 0; n < 12; n++) begin
            checks++; if (got_data[n] != ref_out(n, xv)) begin errors++; $display("FAIL bp_data n=%0d got %0d exp %0d", n, got_data[n], ref_out(n, xv)); end
        end
        checks++; if (stall_unstable) begin errors++; $display("FAIL bp_stable got unstable exp stable"); end
        checks++; if (stall_rom_en)   begin errors++; $display("FAIL bp_rom_enable got 1 exp 0"); end
        checks++; if (stall_acked)    begin errors++; $display("FAIL bp_in_ack got 1 exp 0"); end
        checks++; if (hs_cyc[3] - got_cyc[3] != 5) begin errors++; $display("FAIL bp_hold got %0d exp 5", hs_cyc[3] - got_cyc[3]); end
        checks++; if (got_cyc[4] - hs_cyc[3] != 8) begin errors++; $display("FAIL bp_next got %0d exp 8", got_cyc[4] - hs_cyc[3]); end
    endtask

    task automatic test_back_to_back();
        xvec_t xv;
        do_reset();
        random_tab();
        for (int f = 0; f < 4; f++) begin
            random_x(xv);
            run_frame(xv, 1'($urandom_range(0, 1)), $urandom_range(0, 11), $urandom_range(0, 3));
            checks++; if (timeout) begin errors++; $display("FAIL b2b_timeout f=%0d got 1 exp 0", f); end
            for (int n = 0; n < 12; n++) begin
                checks++; if (got_data[n] != ref_out(n, xv)) begin errors++; $display("FAIL b2b_data f=%0d n=%0d got %0d exp %0d", f, n, got_data[n], ref_out(n, xv)); end
                checks++; if (got_idx[n] != n) begin errors++; $display("FAIL b2b_index f=%0d n=%0d got %0d exp %0d", f, n, got_idx[n], n); end
            end
        end
    endtask

    task automatic test_reset_mid();
        xvec_t xv;
        bit found = 1'b0;
        do_reset();
        random_tab();
        random_x(xv);
        timeout = 1'b0;
        send_frame(xv, 1'b0);
        for (int b = 0; b < 200; b++) begin
            if (out_valid_o && out_index_o == 4'd5) begin
                found = 1'b1;
                break;
            end
            step();
        end
        checks++; if (!found) begin errors++; $display("FAIL mid_reach_idx5 got 0 exp 1"); end
        out_ready_i = 1'b0;
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        out_ready_i = 1'b1;
        checks++; if (out_valid_o !== 1'b0)  begin errors++; $display("FAIL mid_out_valid got %b exp 0", out_valid_o); end
        checks++; if (in_ready_o !== 1'b1)   begin errors++; $display("FAIL mid_in_ready got %b exp 1", in_ready_o); end
        checks++; if (rom_enable_o !== 1'b0) begin errors++; $display("FAIL mid_rom_enable got %b exp 0", rom_enable_o); end
        random_x(xv);
        run_frame(xv, 1'b1, -1, 0);
        checks++; if (timeout) begin errors++; $display("FAIL mid_timeout got 1 exp 0"); end
        for (int n = 0; n < 12; n++) begin
            checks++; if (got_idx[n] != n) begin errors++; $display("FAIL mid_index n=%0d got %0d exp %0d", n, got_idx[n], n); end
            checks++; if (got_data[n] != ref_out(n, xv)) begin errors++; $display("FAIL mid_data n=%0d got %0d exp %0d", n, got_data[n], ref_out(n, xv)); end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_zero_frame();
        test_const_rom();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imdct_short_engine.md
# imdct_short_engine

Computes the 12-point short-block IMDCT for one MP3 short window: accepts six signed frequency lines X[0..5], then produces twelve time samples x[n] = sum over k=0..5 of X[k]·C[n][k]. C[n][k] comes from the short-block cosine coefficient ROM wrapper, which this block drives directly. It sits between the requantize/reorder path (upstream, supplies X) and windowing/overlap-add (downstream, consumes x).

## Interface
- COEF_FRAC, 17: fractional bits of ROM coefficients (signed Q1.17); product right-shift amount.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts input words (LOAD state only).
- in_data  in  18  signed X[k], k in arrival order 0..5.
- rom_enable  out  1  ROM read enable.
- rom_n  out  4  ROM output index n (0..11).
- rom_k  out  3  ROM line index k (0..5).
- rom_data  in  18  signed coefficient, valid the cycle after rom_enable.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  18  signed x[n].
- out_index  out  4  n of current out_data.
- out_last  out  1  high with out_valid when out_index = 11.

## Operation
- States: LOAD, MAC, EMIT.
- LOAD: in_ready = 1. Each in_valid cycle stores in_data into X[load_cnt] and increments load_cnt. After the 6th word, go to MAC with n = 0. The accumulator is cleared on entry.
- MAC: lasts exactly 7 cycles, indexed by cycle counter c = 0..6.
  - For c = 0..5: rom_enable = 1, rom_n = n, rom_k = c.
  - For c = 1..6: acc += rom_data · X[c−1]. The product is a full 36-bit signed value; acc is 39-bit signed.
  - After c = 6, go to EMIT.
- Output formatting on EMIT entry:
  - Round half-up: r = (acc + 2^(COEF_FRAC−1)) >>> COEF_FRAC.
  - Saturate r to [−131072, 131071].
  - Register the result as out_data, with out_index = n.
- EMIT: out_valid = 1; out_data and out_index are held stable until out_valid & out_ready.
  - On handshake with n = 11: go to LOAD, load_cnt = 0.
  - Otherwise: n += 1, clear acc, go to MAC.
- X registers are written only in LOAD. in_valid outside LOAD is ignored and not acknowledged.
- rom_enable = 0 outside MAC cycles 0..5. rom_n and rom_k hold their last value when not enabled.
- Frame boundary: a new frame's words are accepted only after out_last handshakes. No overlap of frames.

## Timing
- Reset values: state LOAD, load_cnt 0, n 0, c 0, acc 0, in_ready 1, rom_enable 0, rom_n 0, rom_k 0, out_valid 0, out_data 0, out_index 0, out_last 0.
- Reset asserted in any state (including mid-MAC or in EMIT): on the next cycle, all reset values apply and the partial frame is discarded. The bench ROM model may still present stale data; it is ignored.
- Input-to-first-output: the 6th input handshake at cycle T gives MAC cycles T+1..T+7 and out_valid at T+8.
- Per output with out_ready held high: 8 cycles (7 MAC + 1 EMIT). The full frame is 96 cycles from MAC entry to last handshake.
- After the last handshake at cycle U: in_ready = 1 at U+1.
- Backpressure: out_ready low stalls indefinitely in EMIT. rom_enable stays 0 and no counters advance.
- out_ready is ignored while out_valid = 0.

## Test plan
- All X = 0, any ROM contents, out_ready = 1 → twelve outputs of 0 with out_index 0..11. out_last only on index 11. out_valid first rises 8 cycles after the 6th input handshake.
- X = [1000, 0, 0, 0, 0, 0], bench ROM returns 65536 for every address → all twelve outputs = 500. rom_k sequence 0..5 per n, rom_n 0..11.
- Rounding:
  - X[0] = 3, others 0, coefficient 65536 → output 2.
  - X[0] = −3 → output −1.
- Saturation:
  - All X = 131071, all coefficients 131071 → 131071.
  - All X = −131072, coefficients 131071 → −131072.
- Backpressure and ignored input: out_ready low for 5 cycles at out_index 3.
  - out_data and out_index stay stable; rom_enable stays 0.
  - Index 4 appears 8 cycles after the handshake.
  - in_valid pulses during this frame are not acknowledged (in_ready = 0).
- Reset mid-frame while EMIT holds out_index 5.
  - Next cycle: out_valid = 0, in_ready = 1, rom_enable = 0.
  - A new 6-word frame then produces out_index starting at 0 with correct values.
